// File: rtl/demorgan_pkg.sv
// demorgan_pkg -- shared definitions for the De Morgan gate self-test checker.
//   state_t          checker FSM states
//   GATE_W           width of the gate output / mismatch vector
//   MSK_*            bit positions inside that vector
//   demorgan_expect  ideal gate outputs for one {a,b} input vector
package demorgan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int GATE_W     = 6;
  localparam int MSK_NA     = 5;
  localparam int MSK_NB     = 4;
  localparam int MSK_NANDNB = 3;
  localparam int MSK_NAORNB = 2;
  localparam int MSK_ANORB  = 1;
  localparam int MSK_ANANDB = 0;

  function automatic logic [GATE_W-1:0] demorgan_expect(input logic a, input logic b);
    logic [GATE_W-1:0] e;
    e             = '0;
    e[MSK_NA]     = ~a;
    e[MSK_NB]     = ~b;
    e[MSK_NANDNB] = ~a & ~b;
    e[MSK_NAORNB] = ~a | ~b;
    e[MSK_ANORB]  = ~(a | b);
    e[MSK_ANANDB] = ~(a & b);
    return e;
  endfunction

endpackage

// File: rtl/demorgan_checker_golden.sv
// demorgan_golden -- combinational ideal-output generator for the De Morgan
// gate block; usable stand-alone as a reference model.
//   a, b    gate input vector
//   golden  ideal outputs, bit order {nA, nB, nAandnB, nAornB, AnorB, AnandB}
module demorgan_golden
  import demorgan_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] golden
);

  assign golden = demorgan_expect(a, b);

endmodule

// File: rtl/demorgan_checker.sv
// demorgan_checker -- drives the De Morgan gate block through all four input
// vectors (LOOPS sweeps), samples its six outputs after SETTLE_CYCLES, counts
// mismatches and records the first failing sample.
//   clk, reset         system clock (rising edge), async active-high reset
//   start              begin a run (accepted only when idle or done)
//   drv_a, drv_b       registered stimulus to the gate block
//   in_*               observed gate outputs
//   busy, done, pass   run status; pass is meaningful while done
//   err_count          failing samples, saturating at 255
//   fail_valid, first_fail_vec, first_fail_mask   first-failure record
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              drv_a,
  output logic              drv_b,
  input  logic              in_na,
  input  logic              in_nb,
  input  logic              in_nandnb,
  input  logic              in_naornb,
  input  logic              in_anorb,
  input  logic              in_anandb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic              fail_valid,
  output logic [1:0]        first_fail_vec,
  output logic [GATE_W-1:0] first_fail_mask
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);

  state_t              state, state_next;
  logic [1:0]          vec, vec_next;
  logic [7:0]          loop_cnt, loop_next;
  logic [7:0]          settle_cnt, settle_next;
  logic                drv_a_next, drv_b_next;
  logic                busy_next, done_next, pass_next;
  logic [7:0]          err_next;
  logic                fail_valid_next;
  logic [1:0]          ffv_next;
  logic [GATE_W-1:0]   ffm_next;
  logic [GATE_W-1:0]   golden, observed, mask;
  logic                accept_start;

  // Expected outputs follow vec, which equals {drv_a, drv_b} while sampling.
  demorgan_golden u_golden (
    .a      (vec[1]),
    .b      (vec[0]),
    .golden (golden)
  );

  assign observed = {in_na, in_nb, in_nandnb, in_naornb, in_anorb, in_anandb};
  assign mask     = observed ^ golden;

  // busy is still high during the first DONE cycle, so a start arriving
  // there is treated as arriving mid-run and ignored.
  assign accept_start = start && !busy && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_next      = state;
    vec_next        = vec;
    loop_next       = loop_cnt;
    settle_next     = settle_cnt;
    drv_a_next      = drv_a;
    drv_b_next      = drv_b;
    busy_next       = busy;
    done_next       = done;
    pass_next       = pass;
    err_next        = err_count;
    fail_valid_next = fail_valid;
    ffv_next        = first_fail_vec;
    ffm_next        = first_fail_mask;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (state == ST_DONE) begin
          busy_next = 1'b0;
          done_next = 1'b1;
          pass_next = (err_count == 8'd0);
        end
        if (accept_start) begin
          state_next      = ST_DRIVE;
          vec_next        = 2'd0;
          loop_next       = 8'd0;
          err_next        = 8'd0;
          fail_valid_next = 1'b0;
          ffv_next        = 2'd0;
          ffm_next        = '0;
          busy_next       = 1'b1;
          done_next       = 1'b0;
          pass_next       = 1'b0;
        end
      end

      ST_DRIVE: begin
        drv_a_next  = vec[1];
        drv_b_next  = vec[0];
        settle_next = SETTLE_LD;
        state_next  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end

      ST_SETTLE: begin
        settle_next = settle_cnt - 8'd1;
        if (settle_cnt <= 8'd1) state_next = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (mask != '0) begin
          if (err_count != 8'hFF) err_next = err_count + 8'd1;
          if (!fail_valid) begin
            fail_valid_next = 1'b1;
            ffv_next        = vec;
            ffm_next        = mask;
          end
        end
        if (vec != 2'd3) begin
          vec_next   = vec + 2'd1;
          state_next = ST_DRIVE;
        end else if (loop_cnt < LAST_LOOP) begin
          vec_next   = 2'd0;
          loop_next  = loop_cnt + 8'd1;
          state_next = ST_DRIVE;
        end else begin
          state_next = ST_DONE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      vec             <= 2'd0;
      loop_cnt        <= 8'd0;
      settle_cnt      <= 8'd0;
      drv_a           <= 1'b0;
      drv_b           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 8'd0;
      fail_valid      <= 1'b0;
      first_fail_vec  <= 2'd0;
      first_fail_mask <= '0;
    end else begin
      state           <= state_next;
      vec             <= vec_next;
      loop_cnt        <= loop_next;
      settle_cnt      <= settle_next;
      drv_a           <= drv_a_next;
      drv_b           <= drv_b_next;
      busy            <= busy_next;
      done            <= done_next;
      pass            <= pass_next;
      err_count       <= err_next;
      fail_valid      <= fail_valid_next;
      first_fail_vec  <= ffv_next;
      first_fail_mask <= ffm_next;
    end
  end

endmodule

// File: tb/tb_demorgan_checker.sv
// tb_demorgan_checker -- self-checking bench for demorgan_checker. Several
// checker instances with different SETTLE_CYCLES/LOOPS each face a table-driven
// gate model; a sweep-level reference model predicts the run result.
module tb_demorgan_checker;

  localparam int N_DUT = 4;
  localparam int SET_P  [N_DUT] = '{2, 2, 0, 0};
  localparam int LOOP_P [N_DUT] = '{1, 3, 1, 100};

  logic       clk = 1'b0;
  logic       reset;
  logic       start_r [N_DUT];
  logic [5:0] obs_tbl [N_DUT][4];

  wire       drv_a_w  [N_DUT];
  wire       drv_b_w  [N_DUT];
  wire       busy_w   [N_DUT];
  wire       done_w   [N_DUT];
  wire       pass_w   [N_DUT];
  wire [7:0] err_w    [N_DUT];
  wire       fv_w     [N_DUT];
  wire [1:0] ffv_w    [N_DUT];
  wire [5:0] ffm_w    [N_DUT];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    // Gate block model: whatever the table says for the driven vector.
    wire [5:0] obs = obs_tbl[g][{drv_a_w[g], drv_b_w[g]}];

    demorgan_checker #(.SETTLE_CYCLES(SET_P[g]), .LOOPS(LOOP_P[g])) u_dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start_r[g]),
      .drv_a           (drv_a_w[g]),
      .drv_b           (drv_b_w[g]),
      .in_na           (obs[5]),
      .in_nb           (obs[4]),
      .in_nandnb       (obs[3]),
      .in_naornb       (obs[2]),
      .in_anorb        (obs[1]),
      .in_anandb       (obs[0]),
      .busy            (busy_w[g]),
      .done            (done_w[g]),
      .pass            (pass_w[g]),
      .err_count       (err_w[g]),
      .fail_valid      (fv_w[g]),
      .first_fail_vec  (ffv_w[g]),
      .first_fail_mask (ffm_w[g])
    );
  end

  // ---------------- reference model ----------------
  // Ideal outputs stated as truth conditions on a and b.
  function automatic logic [5:0] ideal(input int v);
    int a, b;
    logic [5:0] e;
    a = v / 2;
    b = v % 2;
    e[5] = (a == 0);
    e[4] = (b == 0);
    e[3] = (a == 0 && b == 0);
    e[2] = !(a == 1 && b == 1);
    e[1] = (a + b == 0);
    e[0] = (a * b == 0);
    return e;
  endfunction

  typedef struct {
    int         errs;
    bit         fv;
    logic [1:0] fvec;
    logic [5:0] fmask;
  } result_t;

  function automatic result_t model(input int idx);
    result_t r;
    logic [5:0] m;
    r.errs = 0; r.fv = 0; r.fvec = 2'd0; r.fmask = 6'd0;
    for (int l = 0; l < LOOP_P[idx]; l++) begin
      for (int v = 0; v < 4; v++) begin
        m = obs_tbl[idx][v] ^ ideal(v);
        if (m != 6'd0) begin
          r.errs++;
          if (!r.fv) begin
            r.fv = 1; r.fvec = 2'(v); r.fmask = m;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic set_ideal(input int idx);
    for (int v = 0; v < 4; v++) obs_tbl[idx][v] = ideal(v);
  endtask

  task automatic set_random(input int idx);
    for (int v = 0; v < 4; v++)
      obs_tbl[idx][v] = ideal(v) ^ (($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0);
  endtask

  // Start a run on one instance and follow it to done. stray_at > 0 pulses
  // start again at that cycle offset while the run is busy.
  task automatic run_check(input int idx, input string name, input int stray_at);
    result_t r;
    int k, lat, budget, done_at, exp_err;
    bit seen;
    logic [1:0] exp_drv;
    r       = model(idx);
    exp_err = (r.errs > 255) ? 255 : r.errs;
    lat     = 1 + 4 * LOOP_P[idx] * (SET_P[idx] + 2);
    budget  = lat + 20;
    done_at = 0;
    seen    = 0;

    @(negedge clk); start_r[idx] = 1'b1;
    @(posedge clk); #1; k = cyc;
    start_r[idx] = 1'b0;

    compared++;
    if ({busy_w[idx], done_w[idx], err_w[idx], fv_w[idx]} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL %s start_clear: busy/done/err/fv got %b/%b/%0d/%b expected 1/0/0/0",
               name, busy_w[idx], done_w[idx], err_w[idx], fv_w[idx]);
    end

    for (int t = 1; t <= budget && !seen; t++) begin
      if (t == stray_at) begin
        @(negedge clk); start_r[idx] = 1'b1;
      end
      @(posedge clk); #1;
      if (t == stray_at) start_r[idx] = 1'b0;
      if (done_w[idx] === 1'b1) begin
        seen    = 1;
        done_at = cyc - k;
      end else begin
        exp_drv = 2'(((t - 1) / (SET_P[idx] + 2)) % 4);
        compared++;
        if (busy_w[idx] !== 1'b1 || {drv_a_w[idx], drv_b_w[idx]} !== exp_drv) begin
          mismatched++;
          $display("FAIL %s run t=%0d: busy/drv got %b/%b%b expected 1/%b",
                   name, t, busy_w[idx], drv_a_w[idx], drv_b_w[idx], exp_drv);
        end
      end
    end

    compared++;
    if (!seen || done_at != lat) begin
      mismatched++;
      $display("FAIL %s done_latency: got %0d expected %0d (seen=%0d)", name, done_at, lat, seen);
    end
    compared++;
    if (err_w[idx] !== 8'(exp_err) || pass_w[idx] !== (exp_err == 0) || busy_w[idx] !== 1'b0) begin
      mismatched++;
      $display("FAIL %s result: err/pass/busy got %0d/%b/%b expected %0d/%b/0",
               name, err_w[idx], pass_w[idx], busy_w[idx], exp_err, exp_err == 0);
    end
    compared++;
    if ({fv_w[idx], ffv_w[idx], ffm_w[idx]} !== {r.fv, r.fvec, r.fmask}) begin
      mismatched++;
      $display("FAIL %s first_fail: fv/vec/mask got %b/%b/%b expected %b/%b/%b",
               name, fv_w[idx], ffv_w[idx], ffm_w[idx], r.fv, r.fvec, r.fmask);
    end

    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (done_w[idx] !== 1'b1 || {drv_a_w[idx], drv_b_w[idx]} !== 2'b11) begin
      mismatched++;
      $display("FAIL %s done_hold: done/drv got %b/%b%b expected 1/11",
               name, done_w[idx], drv_a_w[idx], drv_b_w[idx]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #10;
    for (int i = 0; i < N_DUT; i++) begin
      compared++;
      if ({drv_a_w[i], drv_b_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i],
           fv_w[i], ffv_w[i], ffm_w[i]} !== 21'd0) begin
        mismatched++;
        $display("FAIL reset_state[%0d]: drv=%b%b busy=%b done=%b pass=%b err=%0d fv=%b expected all zero",
                 i, drv_a_w[i], drv_b_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i]);
      end
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_ideal();
    set_ideal(0);
    run_check(0, "ideal", 0);
  endtask

  task automatic test_stuck_anandb();
    set_ideal(0);
    for (int v = 0; v < 4; v++) obs_tbl[0][v][0] = 1'b0;
    run_check(0, "stuck_anandb", 0);
  endtask

  task automatic test_crosswire();
    logic [5:0] e;
    for (int v = 0; v < 4; v++) begin
      e = ideal(v);
      obs_tbl[1][v] = {e[4], e[5], e[3:0]};
    end
    run_check(1, "crosswire", 0);
  endtask

  task automatic test_back_to_back();
    set_random(1);
    run_check(1, "back_to_back", 0);
    set_ideal(1);
    run_check(1, "back_to_back_clean", 0);
  endtask

  task automatic test_stray_start();
    set_random(0);
    run_check(0, "stray_start", int'($urandom_range(2, 15)));
  endtask

  task automatic test_settle0();
    set_ideal(2);
    run_check(2, "settle0_ideal", 0);
    set_random(2);
    run_check(2, "settle0_random", 0);
  endtask

  task automatic test_saturation();
    for (int v = 0; v < 4; v++) obs_tbl[3][v] = 6'd0;
    run_check(3, "saturation", 0);
    set_random(3);
    run_check(3, "long_random", 0);
  endtask

  task automatic test_random();
    int idx, lat;
    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, 2));
      lat = 1 + 4 * LOOP_P[idx] * (SET_P[idx] + 2);
      set_random(idx);
      run_check(idx, "random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, lat - 2)) : 0);
    end
  endtask

  task automatic test_mid_run_reset();
    int pre_err;
    set_random(0);
    obs_tbl[0][0] = ideal(0) ^ 6'b100000;
    pre_err = 0;
    for (int v = 0; v < 2; v++) if (obs_tbl[0][v] != ideal(v)) pre_err++;

    @(negedge clk); start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    compared++;
    if ({drv_a_w[0], drv_b_w[0]} !== 2'b10 || err_w[0] !== 8'(pre_err)) begin
      mismatched++;
      $display("FAIL mid_reset_pre: drv/err got %b%b/%0d expected 10/%0d",
               drv_a_w[0], drv_b_w[0], err_w[0], pre_err);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({busy_w[0], done_w[0], drv_a_w[0], drv_b_w[0], err_w[0], fv_w[0]} !== 13'd0) begin
      mismatched++;
      $display("FAIL mid_reset_async: busy=%b done=%b drv=%b%b err=%0d fv=%b expected all zero",
               busy_w[0], done_w[0], drv_a_w[0], drv_b_w[0], err_w[0], fv_w[0]);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({busy_w[0], done_w[0], drv_a_w[0], drv_b_w[0]} !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_reset_idle: busy/done/drv got %b/%b/%b%b expected 0/0/00",
               busy_w[0], done_w[0], drv_a_w[0], drv_b_w[0]);
    end
    set_ideal(0);
    run_check(0, "after_reset", 0);
  endtask

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      start_r[i] = 1'b0;
      set_ideal(i);
    end
    test_reset();
    test_ideal();
    test_stuck_anandb();
    test_crosswire();
    test_back_to_back();
    test_stray_start();
    test_settle0();
    test_saturation();
    test_random();
    test_mid_run_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
